cpu_bus_sequencer: RTL and testbench

//  Owns the CPU's T-cycle counter and performs one memory access per M-cycle for the

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cpu_bus_watchdog.sv | 32 +++
 rtl/cpu_bus_sequencer.sv | 97 +++++++++
 tb/tb_cpu_bus_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: T-cycle phase constants, default bus widths,
// the NOP opcode and the program-counter source selector.
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 8;

    localparam logic [1:0] T_COMPLETE = 2'd0;
    localparam logic [1:0] T_ADVANCE  = 2'd1;
    localparam logic [1:0] T_CAPTURE  = 2'd2;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_JUMP = 2'd1,
        PC_REL  = 2'd2,
        PC_HOLD = 2'd3
    } pc_next_e;

endpackage

// File: rtl/cpu_bus_watchdog.sv
// Counts clocks spent stalled on the bus and flags a forced completion
// once the count reaches STALL_LIMIT (STALL_LIMIT of 0 disables the timeout).
module cpu_bus_watchdog
    import cpu_pkg::*;
#(
    parameter int STALL_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = (STALL_LIMIT == 0) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count;

    assign timeout = (STALL_LIMIT != 0) && enable && (count == LIMIT);

    // Saturates rather than wrapping so a disabled watchdog can stall forever.
    always_ff @(posedge clk) begin
        if (reset || clear || timeout) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// T-cycle sequencer and external bus master: one access per M-cycle
// (capture at t2, strobes through t3/t0, complete at t0), with stall and timeout.
module cpu_bus_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEFAULT,
    parameter int                DATA_W      = DATA_W_DEFAULT,
    parameter int                STALL_LIMIT = 255,
    parameter logic [DATA_W-1:0] RESET_IR    = DATA_W'(NOP_OPCODE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              mem_write,
    input  logic              inst_load,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        t_cycle,
    output logic              stall,
    output logic [DATA_W-1:0] instruction_register,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_rd,
    output logic              bus_wr,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              bus_timeout
);

    logic              ld_ir;
    logic              access_at_t0;
    logic              stall_raw;
    logic              timeout;
    logic              complete;
    logic [DATA_W-1:0] read_value;

    // bus_ready only matters while an access is waiting in its completion phase.
    assign access_at_t0 = (bus_rd || bus_wr) && (t_cycle == T_COMPLETE);
    assign stall_raw    = access_at_t0 && !bus_ready;
    assign stall        = stall_raw && !timeout;
    assign complete     = access_at_t0 && (bus_ready || timeout);
    assign read_value   = timeout ? {DATA_W{1'b1}} : bus_rdata;

    cpu_bus_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (complete),
        .enable (stall_raw),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            t_cycle              <= T_COMPLETE;
            bus_rd               <= 1'b0;
            bus_wr               <= 1'b0;
            bus_addr             <= '0;
            bus_wdata            <= '0;
            mem_rdata            <= '0;
            instruction_register <= RESET_IR;
            ld_ir                <= 1'b0;
            bus_timeout          <= 1'b0;
        end else begin
            bus_timeout <= timeout;

            if (!stall) begin
                t_cycle <= t_cycle + 2'd1;
            end

            // Control outputs are settled by t2, so the access is latched here.
            if (t_cycle == T_CAPTURE) begin
                bus_rd <= mem_enable && !mem_write;
                bus_wr <= mem_enable && mem_write;
                ld_ir  <= inst_load;
                if (mem_enable) begin
                    bus_addr  <= mem_addr;
                    bus_wdata <= mem_wdata;
                end
            end

            if (complete) begin
                bus_rd <= 1'b0;
                bus_wr <= 1'b0;
                if (bus_rd) begin
                    mem_rdata <= read_value;
                    if (ld_ir) begin
                        instruction_register <= read_value;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer: free-run, read with IR load, write,
// short stall, watchdog timeout, idle cycle and reset during a stalled read.
module tb_cpu_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_enable;
    logic        mem_write;
    logic        inst_load;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [1:0]  t_cycle;
    logic        stall;
    logic [7:0]  instruction_register;
    logic [7:0]  mem_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_rdata;
    logic        bus_ready;
    logic        bus_timeout;

    int checks_total  = 0;
    int checks_failed = 0;

    cpu_bus_sequencer #(
        .ADDR_W     (16),
        .DATA_W     (8),
        .STALL_LIMIT(4),
        .RESET_IR   (8'h00)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_enable          (mem_enable),
        .mem_write           (mem_write),
        .inst_load           (inst_load),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .t_cycle             (t_cycle),
        .stall               (stall),
        .instruction_register(instruction_register),
        .mem_rdata           (mem_rdata),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_rd              (bus_rd),
        .bus_wr              (bus_wr),
        .bus_rdata           (bus_rdata),
        .bus_ready           (bus_ready),
        .bus_timeout         (bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic en, input logic wr, input logic ld,
                                  input logic [15:0] addr, input logic [7:0] wdata,
                                  input logic [7:0] rdata, input logic ready);
        mem_enable = en;
        mem_write  = wr;
        inst_load  = ld;
        mem_addr   = addr;
        mem_wdata  = wdata;
        bus_rdata  = rdata;
        bus_ready  = ready;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks_total++;
        assert (observed === expected)
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        check_output("rst_t_cycle", 32'(t_cycle), 32'd0);
        check_output("rst_ir", 32'(instruction_register), 32'h00);
        check_output("rst_strobes", {30'd0, bus_rd, bus_wr}, 32'd0);
        check_output("rst_addr", 32'(bus_addr), 32'h0000);
        check_output("rst_rdata", 32'(mem_rdata), 32'h00);
        check_output("rst_timeout", 32'(bus_timeout), 32'd0);

        // Free-run with no access; bus_ready high should not matter.
        reset = 1'b0;
        bus_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_output("free_t_cycle", 32'(t_cycle), 32'(k % 4));
            check_output("free_strobes", {30'd0, bus_rd, bus_wr}, 32'd0);
        end
        check_output("free_ir", 32'(instruction_register), 32'h00);

        // Read 0x0150 with IR load; now at t0.
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'h0150, 8'h00, 8'h3E, 1'b1);
        tick();
        tick();
        check_output("rd_t2_no_strobe", 32'(bus_rd), 32'd0);
        tick();
        check_output("rd_t3_phase", 32'(t_cycle), 32'd3);
        check_output("rd_t3_rd", 32'(bus_rd), 32'd1);
        check_output("rd_t3_wr", 32'(bus_wr), 32'd0);
        check_output("rd_t3_addr", 32'(bus_addr), 32'h0150);
        tick();
        check_output("rd_t0_phase", 32'(t_cycle), 32'd0);
        check_output("rd_t0_rd", 32'(bus_rd), 32'd1);
        check_output("rd_t0_stall", 32'(stall), 32'd0);
        tick();
        check_output("rd_t1_phase", 32'(t_cycle), 32'd1);
        check_output("rd_t1_rd", 32'(bus_rd), 32'd0);
        check_output("rd_t1_ir", 32'(instruction_register), 32'h3E);
        check_output("rd_t1_rdata", 32'(mem_rdata), 32'h3E);

        // Write 0xFF40 <= 0x91 with inst_load set, which must be ignored.
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'hFF40, 8'h91, 8'h55, 1'b1);
        tick();
        tick();
        check_output("wr_t3_wr", 32'(bus_wr), 32'd1);
        check_output("wr_t3_rd", 32'(bus_rd), 32'd0);
        check_output("wr_t3_addr", 32'(bus_addr), 32'hFF40);
        check_output("wr_t3_wdata", 32'(bus_wdata), 32'h91);
        tick();
        check_output("wr_t0_wr", 32'(bus_wr), 32'd1);
        tick();
        check_output("wr_t1_wr", 32'(bus_wr), 32'd0);
        check_output("wr_t1_rdata", 32'(mem_rdata), 32'h3E);
        check_output("wr_t1_ir", 32'(instruction_register), 32'h3E);

        // Read 0x1234 with bus_ready low for three clocks.
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0);
        tick();
        tick();
        check_output("st_t3_rd", 32'(bus_rd), 32'd1);
        tick();
        for (int s = 0; s < 3; s++) begin
            check_output("st_stall", 32'(stall), 32'd1);
            check_output("st_phase", 32'(t_cycle), 32'd0);
            check_output("st_rd_held", 32'(bus_rd), 32'd1);
            check_output("st_addr_held", 32'(bus_addr), 32'h1234);
            tick();
        end
        bus_ready = 1'b1;
        #1;
        check_output("st_ready_stall", 32'(stall), 32'd0);
        tick();
        check_output("st_done_phase", 32'(t_cycle), 32'd1);
        check_output("st_done_rdata", 32'(mem_rdata), 32'hA5);
        check_output("st_done_ir", 32'(instruction_register), 32'h3E);
        check_output("st_done_rd", 32'(bus_rd), 32'd0);
        check_output("st_no_timeout", 32'(bus_timeout), 32'd0);

        // Read with bus_ready stuck low; watchdog limit is 4.
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'h2000, 8'h00, 8'h77, 1'b0);
        tick();
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            check_output("to_stall", 32'(stall), 32'd1);
            check_output("to_phase", 32'(t_cycle), 32'd0);
            check_output("to_pulse_early", 32'(bus_timeout), 32'd0);
            tick();
        end
        check_output("to_forced_stall", 32'(stall), 32'd0);
        mem_enable = 1'b0;
        tick();
        check_output("to_phase_after", 32'(t_cycle), 32'd1);
        check_output("to_ir", 32'(instruction_register), 32'hFF);
        check_output("to_rdata", 32'(mem_rdata), 32'hFF);
        check_output("to_pulse", 32'(bus_timeout), 32'd1);
        check_output("to_rd_cleared", 32'(bus_rd), 32'd0);
        tick();
        check_output("to_pulse_end", 32'(bus_timeout), 32'd0);

        // Idle M-cycle with bus_ready low must not stall.
        tick();
        check_output("idle_t3_rd", 32'(bus_rd), 32'd0);
        tick();
        check_output("idle_t0_stall", 32'(stall), 32'd0);
        tick();
        check_output("idle_t1_phase", 32'(t_cycle), 32'd1);

        // Reset during a stalled read.
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'h3000, 8'h00, 8'h42, 1'b0);
        tick();
        tick();
        tick();
        check_output("rs_stall", 32'(stall), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check_output("rs_strobes", {30'd0, bus_rd, bus_wr}, 32'd0);
        check_output("rs_phase", 32'(t_cycle), 32'd0);
        check_output("rs_ir", 32'(instruction_register), 32'h00);
        check_output("rs_timeout", 32'(bus_timeout), 32'd0);
        reset = 1'b0;
        mem_enable = 1'b0;
        tick();
        check_output("rs_after_timeout", 32'(bus_timeout), 32'd0);
        check_output("rs_after_phase", 32'(t_cycle), 32'd1);

        $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
        $finish;
    end

endmodule
